// File: rtl/encoder_pipe_nxm.sv
// Two-stage pipelined N-to-log2(N) encoder with valid/ready flow control
// and a saturating count of delivered error results.
module encoder_pipe_nxm #(
  parameter  int IN_W  = 16,
  parameter  int MODE  = 0,
  parameter  int CNT_W = 8,
  localparam int OUT_W = $clog2(IN_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out,
  output logic             err,
  output logic             zero,
  output logic [CNT_W-1:0] err_count,
  input  logic             clr_count
);

  logic             rdy_q;
  logic             s1_valid_q, s1_valid_d;
  logic [IN_W-1:0]  s1_data_q;
  logic             out_valid_q;
  logic [OUT_W-1:0] out_q, out_d;
  logic             err_q, err_d;
  logic             zero_q, zero_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;

  logic             s2_load;
  logic             in_fire;
  logic [OUT_W-1:0] hi_idx, lo_idx;
  logic             found, multi;

  // rdy_q keeps in_ready low through reset and until the first edge after it
  assign s2_load    = !out_valid_q || out_ready;
  assign in_ready   = rdy_q && (!s1_valid_q || s2_load);
  assign in_fire    = in_valid && in_ready;
  assign s1_valid_d = in_fire || (s1_valid_q && !s2_load);

  always_comb begin
    hi_idx = '0;
    lo_idx = '0;
    found  = 1'b0;
    multi  = 1'b0;
    for (int i = 0; i < IN_W; i++) begin
      if (s1_data_q[i]) begin
        hi_idx = OUT_W'(i);
        if (!found) lo_idx = OUT_W'(i);
        if (found) multi = 1'b1;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    out_d  = '0;
    err_d  = 1'b0;
    zero_d = !found;
    case (MODE)
      0: begin
        out_d = (found && !multi) ? hi_idx : '0;
        err_d = !(found && !multi);
      end
      1:       out_d = hi_idx;
      default: out_d = lo_idx;
    endcase
  end

  // clear has priority over a same-cycle increment
  always_comb begin
    err_count_d = err_count_q;
    if (clr_count)
      err_count_d = '0;
    else if (out_valid_q && out_ready && err_q && (err_count_q != '1))
      err_count_d = err_count_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_q       <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      err_q       <= 1'b0;
      zero_q      <= 1'b0;
      err_count_q <= '0;
    end else begin
      rdy_q       <= 1'b1;
      s1_valid_q  <= s1_valid_d;
      err_count_q <= err_count_d;
      if (in_fire) s1_data_q <= in;
      if (s2_load) out_valid_q <= s1_valid_q;
      if (s2_load && s1_valid_q) begin
        out_q  <= out_d;
        err_q  <= err_d;
        zero_q <= zero_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign err       = err_q;
  assign zero      = zero_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_encoder_pipe_nxm.sv
// Bench: four encoder instances (modes 0/1/2, plus mode 0 with a 2-bit
// counter) share stimulus and are checked against a queue-based model.
module tb_encoder_pipe_nxm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        clr_count = 1'b0;
  logic [15:0] in_v = '0;

  logic       ir [4];
  logic       ov [4];
  logic       er [4];
  logic       zr [4];
  logic [3:0] o  [4];
  logic [7:0] ecw [4];
  logic [1:0] ec3;

  assign ecw[3] = {6'b0, ec3};

  always #5 clk = ~clk;

  encoder_pipe_nxm #(.IN_W(16), .MODE(0), .CNT_W(8)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]),
    .in(in_v), .out_valid(ov[0]), .out_ready(out_ready), .out(o[0]),
    .err(er[0]), .zero(zr[0]), .err_count(ecw[0]), .clr_count(clr_count)
  );
  encoder_pipe_nxm #(.IN_W(16), .MODE(1), .CNT_W(8)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]),
    .in(in_v), .out_valid(ov[1]), .out_ready(out_ready), .out(o[1]),
    .err(er[1]), .zero(zr[1]), .err_count(ecw[1]), .clr_count(clr_count)
  );
  encoder_pipe_nxm #(.IN_W(16), .MODE(2), .CNT_W(8)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]),
    .in(in_v), .out_valid(ov[2]), .out_ready(out_ready), .out(o[2]),
    .err(er[2]), .zero(zr[2]), .err_count(ecw[2]), .clr_count(clr_count)
  );
  encoder_pipe_nxm #(.IN_W(16), .MODE(0), .CNT_W(2)) u3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[3]),
    .in(in_v), .out_valid(ov[3]), .out_ready(out_ready), .out(o[3]),
    .err(er[3]), .zero(zr[3]), .err_count(ec3), .clr_count(clr_count)
  );

  typedef struct {
    logic [15:0] v;
    int          t;
  } item_t;

  item_t q [$];
  int    md [4] = '{0, 1, 2, 0};
  int    mx [4] = '{255, 255, 255, 3};
  int    ec_m [4];
  bit    rdy_m;
  int    cyc;
  bit    last_acc;
  int    n_cmp;
  int    n_err;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {zero, err, out} from the encoding rules
  function automatic logic [5:0] ref_enc(int m, logic [15:0] v);
    int hi = 0;
    int lo = 0;
    bit f = 0;
    logic [3:0] r;
    logic e;
    for (int i = 0; i < 16; i++) begin
      if (v[i]) begin
        hi = i;
        if (!f) lo = i;
        f = 1;
      end
    end
    e = 1'b0;
    if (m == 0) begin
      e = ($countones(v) != 1);
      r = e ? 4'd0 : 4'(hi);
    end else if (m == 1) begin
      r = 4'(hi);
    end else begin
      r = 4'(lo);
    end
    return {(v == 16'h0), e, r};
  endfunction

  task automatic cycle();
    bit xr, xv, dlv;
    logic [5:0] r;
    #1;
    xr = rdy_m && !(q.size() == 2 && !out_ready);
    xv = (q.size() == 2) || (q.size() == 1 && q[0].t != cyc);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("u%0d.in_ready", k), 32'(ir[k]), 32'(xr));
      chk($sformatf("u%0d.out_valid", k), 32'(ov[k]), 32'(xv));
      chk($sformatf("u%0d.err_count", k), 32'(ecw[k]), 32'(ec_m[k]));
      if (xv) begin
        r = ref_enc(md[k], q[0].v);
        chk($sformatf("u%0d.out", k), 32'(o[k]), 32'(r[3:0]));
        chk($sformatf("u%0d.err", k), 32'(er[k]), 32'(r[4]));
        chk($sformatf("u%0d.zero", k), 32'(zr[k]), 32'(r[5]));
      end
    end
    last_acc = in_valid && xr;
    dlv = xv && out_ready;
    @(posedge clk);
    cyc++;
    for (int k = 0; k < 4; k++) begin
      if (clr_count) begin
        ec_m[k] = 0;
      end else if (dlv) begin
        r = ref_enc(md[k], q[0].v);
        if (r[4] && ec_m[k] < mx[k]) ec_m[k]++;
      end
    end
    if (dlv) void'(q.pop_front());
    if (last_acc) q.push_back('{v: in_v, t: cyc});
    rdy_m = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst.u%0d.in_ready", k), 32'(ir[k]), 0);
      chk($sformatf("rst.u%0d.out_valid", k), 32'(ov[k]), 0);
      chk($sformatf("rst.u%0d.out", k), 32'(o[k]), 0);
      chk($sformatf("rst.u%0d.err", k), 32'(er[k]), 0);
      chk($sformatf("rst.u%0d.zero", k), 32'(zr[k]), 0);
      chk($sformatf("rst.u%0d.err_count", k), 32'(ecw[k]), 0);
      ec_m[k] = 0;
    end
    q.delete();
    rdy_m = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send(logic [15:0] v, int max, output bit ok);
    in_valid = 1'b1;
    in_v = v;
    ok = 1'b0;
    for (int n = 0; n < max && !ok; n++) begin
      cycle();
      ok = last_acc;
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  function automatic logic [15:0] rnd_vec();
    case ($urandom_range(0, 3))
      0: return 16'(1) << $urandom_range(0, 15);
      1: return 16'h0;
      2: return 16'($urandom);
      default: return (16'(1) << $urandom_range(0, 15))
                    | (16'(1) << $urandom_range(0, 15));
    endcase
  endfunction

  initial begin
    bit ok;
    logic [15:0] mh [5] = '{16'h0003, 16'h0005, 16'h00F0, 16'hFFFF, 16'h0101};
    @(negedge clk);
    do_reset();
    cycle();

    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      send(16'(1) << i, 1, ok);
      chk("b2b_acc", 32'(ok), 1);
    end
    idle(3);

    send(16'h0003, 4, ok);
    send(16'h0000, 4, ok);
    idle(3);
    chk("cnt_after_err", 32'(ecw[0]), 2);
    send(16'h0003, 4, ok);
    send(16'h8008, 4, ok);
    idle(3);
    chk("mode1_cnt", 32'(ecw[1]), 0);
    chk("mode2_cnt", 32'(ecw[2]), 0);

    out_ready = 1'b0;
    send(16'h0010, 4, ok);
    chk("bp_acc1", 32'(ok), 1);
    send(16'h0100, 4, ok);
    chk("bp_acc2", 32'(ok), 1);
    send(16'h1000, 3, ok);
    chk("bp_stall", 32'(ok), 0);
    chk("bp_hold", 32'(o[0]), 4);
    out_ready = 1'b1;
    send(16'h1000, 4, ok);
    chk("bp_acc3", 32'(ok), 1);
    idle(4);

    clr_count = 1'b1;
    cycle();
    clr_count = 1'b0;
    for (int i = 0; i < 5; i++) send(mh[i], 4, ok);
    idle(3);
    chk("sat_cnt", 32'(ec3), 3);
    send(16'h0003, 4, ok);
    cycle();
    clr_count = 1'b1;
    cycle();
    clr_count = 1'b0;
    chk("clr_wins", 32'(ec3), 0);
    idle(2);

    for (int n = 0; n < 3000; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_v      = rnd_vec();
      out_ready = ($urandom_range(0, 2) != 0);
      clr_count = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 499) == 0) do_reset();
      else cycle();
    end
    in_valid = 1'b0;
    clr_count = 1'b0;

    out_ready = 1'b0;
    send(16'h0003, 4, ok);
    send(16'h0040, 4, ok);
    chk("full_before_rst", 32'(ov[0]), 1);
    do_reset();
    out_ready = 1'b1;
    idle(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
